// File: rtl/if_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller: state encodings,
// the NOP word delivered on error, and the common enable/stall levels.
package if_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        FetchIdle    = 2'd0,
        FetchReq     = 2'd1,
        FetchDeliver = 2'd2,
        FetchDrain   = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NopInst     = 32'h0000_0000;

    localparam logic        ChipEnable  = 1'b1;
    localparam logic        ChipDisable = 1'b0;

    localparam logic        Stop        = 1'b1;
    localparam logic        NoStop      = 1'b0;

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Instruction bus between the fetch controller (master) and memory (slave).
// Single-cycle ack; read data is valid in the same cycle as the ack.
interface if_fetch_ctrl_if;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_ack_i;
    logic [31:0] ibus_data_i;

    modport master (
        output ibus_req_o,
        output ibus_addr_o,
        input  ibus_ack_i,
        input  ibus_data_i
    );

    modport slave (
        input  ibus_req_o,
        input  ibus_addr_o,
        output ibus_ack_i,
        output ibus_data_i
    );
endinterface

// File: rtl/if_fetch_ctrl_fetch_timer.sv
// Bus-wait timer: clear/increment counter with a terminal-count flag that
// fires in the last cycle allowed before the fetch controller gives up.
module if_fetch_ctrl_fetch_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic tc_o
);
    localparam int unsigned W = $clog2(TIMEOUT);
    localparam logic [W-1:0] TcValue = W'(TIMEOUT - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == TcValue);

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch bus controller between the PC register and IF/ID.
//
//  state        | meaning
//  -------------+--------------------------------------------------------
//  FetchIdle    | no bus access; waiting for ce_i with a fresh PC
//  FetchReq     | request outstanding, ack or timeout ends it
//  FetchDeliver | if_valid_o=1, holding the slot until IF/ID captures it
//  FetchDrain   | flushed while outstanding; swallow the ack, deliver nothing
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] NOP_INST = NopInst
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            pc_i,
    input  logic                   ce_i,
    input  logic [5:0]             stall,
    input  logic                   flush,
    if_fetch_ctrl_if.master        ibus,
    output logic                   stallreq_o,
    output logic [31:0]            if_pc_o,
    output logic [31:0]            if_inst_o,
    output logic                   if_valid_o,
    output logic                   if_err_o
);

    fetch_state_e state_q;
    logic         req_q;
    logic [31:0]  addr_q;
    logic [31:0]  pc_q;
    logic [31:0]  inst_q;
    logic         valid_q;
    logic         err_q;

    logic         tmr_clr;
    logic         tmr_inc;
    logic         tmr_tc;
    logic         outstanding;

    // Only stall[1] matters to this stage.
    logic         unused_stall;
    assign unused_stall = ^{stall[5:2], stall[0]};

    // The timer runs across REQ and DRAIN so a flush does not extend the budget.
    assign outstanding = (state_q == FetchReq) || (state_q == FetchDrain);
    assign tmr_clr     = !outstanding;
    assign tmr_inc     = outstanding && !ibus.ibus_ack_i;

    if_fetch_ctrl_fetch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr_i (tmr_clr),
        .inc_i (tmr_inc),
        .tc_o  (tmr_tc)
    );

    // Fetch FSM with registered bus and IF/ID outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FetchIdle;
            req_q   <= 1'b0;
            addr_q  <= '0;
            pc_q    <= '0;
            inst_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                FetchIdle: begin
                    if (ce_i == ChipEnable && !flush) begin
                        if (pc_i[1:0] == 2'b00) begin
                            addr_q  <= pc_i;
                            req_q   <= 1'b1;
                            state_q <= FetchReq;
                        end else begin
                            pc_q    <= pc_i;
                            inst_q  <= NOP_INST;
                            err_q   <= 1'b1;
                            valid_q <= 1'b1;
                            state_q <= FetchDeliver;
                        end
                    end
                end
                FetchReq: begin
                    if (ibus.ibus_ack_i) begin
                        req_q <= 1'b0;
                        if (flush) begin
                            state_q <= FetchIdle;
                        end else begin
                            inst_q  <= ibus.ibus_data_i;
                            pc_q    <= addr_q;
                            err_q   <= 1'b0;
                            valid_q <= 1'b1;
                            state_q <= FetchDeliver;
                        end
                    end else if (flush) begin
                        // Never abort a bus cycle; let DRAIN absorb the ack.
                        state_q <= FetchDrain;
                    end else if (tmr_tc) begin
                        req_q   <= 1'b0;
                        pc_q    <= addr_q;
                        inst_q  <= NOP_INST;
                        err_q   <= 1'b1;
                        valid_q <= 1'b1;
                        state_q <= FetchDeliver;
                    end
                end
                FetchDrain: begin
                    if (ibus.ibus_ack_i || tmr_tc) begin
                        req_q   <= 1'b0;
                        state_q <= FetchIdle;
                    end
                end
                FetchDeliver: begin
                    if (flush || stall[1] == NoStop) begin
                        valid_q <= 1'b0;
                        state_q <= FetchIdle;
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                    state_q <= FetchIdle;
                end
            endcase
        end
    end

    assign stallreq_o = (state_q == FetchIdle && ce_i == ChipEnable && !flush)
                      || outstanding;

    assign ibus.ibus_req_o  = req_q;
    assign ibus.ibus_addr_o = addr_q;
    assign if_pc_o          = pc_q;
    assign if_inst_o        = inst_q;
    assign if_valid_o       = valid_q;
    assign if_err_o         = err_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl: one instance with the default timeout
// and one with TIMEOUT=4 for the timeout scenarios.
module tb_if_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [31:0] pc;
    logic        ce;
    logic [5:0]  stall;
    logic        flush;
    logic        stallreq;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;
    logic        if_err;

    logic [31:0] pc4;
    logic        ce4;
    logic [5:0]  stall4;
    logic        flush4;
    logic        stallreq4;
    logic [31:0] if_pc4;
    logic [31:0] if_inst4;
    logic        if_valid4;
    logic        if_err4;

    int n_tests = 0;
    int n_fail  = 0;

    if_fetch_ctrl_if bus ();
    if_fetch_ctrl_if bus4 ();

    always #5 clk = ~clk;

    if_fetch_ctrl dut (
        .clk        (clk),
        .rst        (rst_n),
        .pc_i       (pc),
        .ce_i       (ce),
        .stall      (stall),
        .flush      (flush),
        .ibus       (bus),
        .stallreq_o (stallreq),
        .if_pc_o    (if_pc),
        .if_inst_o  (if_inst),
        .if_valid_o (if_valid),
        .if_err_o   (if_err)
    );

    if_fetch_ctrl #(.TIMEOUT(4)) dut4 (
        .clk        (clk),
        .rst        (rst_n),
        .pc_i       (pc4),
        .ce_i       (ce4),
        .stall      (stall4),
        .flush      (flush4),
        .ibus       (bus4),
        .stallreq_o (stallreq4),
        .if_pc_o    (if_pc4),
        .if_inst_o  (if_inst4),
        .if_valid_o (if_valid4),
        .if_err_o   (if_err4)
    );

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        #7;
        n_tests++; if (bus.ibus_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %h expected 0", bus.ibus_req_o); end
        n_tests++; if (bus.ibus_addr_o !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h expected 0", bus.ibus_addr_o); end
        n_tests++; if ({if_pc, if_inst} !== 64'h0) begin n_fail++; $display("FAIL rst_pc_inst: got %h expected 0", {if_pc, if_inst}); end
        n_tests++; if ({if_valid, if_err, stallreq} !== 3'b000) begin n_fail++; $display("FAIL rst_flags: got %b expected 000", {if_valid, if_err, stallreq}); end
        n_tests++; if (bus4.ibus_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_req4: got %h expected 0", bus4.ibus_req_o); end
        #1 rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_fetch();
        ce = 1'b1; pc = 32'h4;
        #1;
        n_tests++; if (stallreq !== 1'b1) begin n_fail++; $display("FAIL f_idle_stallreq: got %h expected 1", stallreq); end
        cyc();
        n_tests++; if (bus.ibus_req_o !== 1'b1) begin n_fail++; $display("FAIL f_req: got %h expected 1", bus.ibus_req_o); end
        n_tests++; if (bus.ibus_addr_o !== 32'h4) begin n_fail++; $display("FAIL f_addr: got %h expected 4", bus.ibus_addr_o); end
        n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL f_valid_req: got %h expected 0", if_valid); end
        cyc();
        n_tests++; if (bus.ibus_req_o !== 1'b1) begin n_fail++; $display("FAIL f_req2: got %h expected 1", bus.ibus_req_o); end
        bus.ibus_ack_i = 1'b1; bus.ibus_data_i = 32'h3C01_1234;
        cyc();
        bus.ibus_ack_i = 1'b0; bus.ibus_data_i = 32'h0;
        n_tests++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL f_valid: got %h expected 1", if_valid); end
        n_tests++; if (if_inst !== 32'h3C01_1234) begin n_fail++; $display("FAIL f_inst: got %h expected 3c011234", if_inst); end
        n_tests++; if (if_pc !== 32'h4) begin n_fail++; $display("FAIL f_pc: got %h expected 4", if_pc); end
        n_tests++; if (if_err !== 1'b0) begin n_fail++; $display("FAIL f_err: got %h expected 0", if_err); end
        n_tests++; if (bus.ibus_req_o !== 1'b0) begin n_fail++; $display("FAIL f_req_drop: got %h expected 0", bus.ibus_req_o); end
        n_tests++; if (stallreq !== 1'b0) begin n_fail++; $display("FAIL f_deliver_stallreq: got %h expected 0", stallreq); end
        ce = 1'b0;
        cyc();
        n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL f_valid_one: got %h expected 0", if_valid); end
        n_tests++; if (stallreq !== 1'b0) begin n_fail++; $display("FAIL f_idle_ce0: got %h expected 0", stallreq); end
    endtask

    task automatic test_stall();
        ce = 1'b1; pc = 32'h8;
        cyc();
        n_tests++; if (bus.ibus_addr_o !== 32'h8) begin n_fail++; $display("FAIL s_addr: got %h expected 8", bus.ibus_addr_o); end
        cyc();
        bus.ibus_ack_i = 1'b1; bus.ibus_data_i = 32'h1111_2222;
        cyc();
        bus.ibus_ack_i = 1'b0; bus.ibus_data_i = 32'h0;
        stall = 6'b000010;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) stall = 6'b000000;
            n_tests++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL s_valid[%0d]: got %h expected 1", i, if_valid); end
            n_tests++; if ({if_pc, if_inst} !== {32'h8, 32'h1111_2222}) begin n_fail++; $display("FAIL s_hold[%0d]: got %h expected 0000000811112222", i, {if_pc, if_inst}); end
            n_tests++; if ({bus.ibus_req_o, stallreq} !== 2'b00) begin n_fail++; $display("FAIL s_noreq[%0d]: got %b expected 00", i, {bus.ibus_req_o, stallreq}); end
            cyc();
        end
        n_tests++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL s_release: got %h expected 0", if_valid); end
        n_tests++; if (bus.ibus_req_o !== 1'b0) begin n_fail++; $display("FAIL s_idle_req: got %h expected 0", bus.ibus_req_o); end
        cyc();
        n_tests++; if (bus.ibus_req_o !== 1'b1) begin n_fail++; $display("FAIL s_next_req: got %h expected 1", bus.ibus_req_o); end
        bus.ibus_ack_i = 1'b1; bus.ibus_data_i = 32'h7777_8888;
        cyc();
        bus.ibus_ack_i = 1'b0; bus.ibus_data_i = 32'h0;
        ce = 1'b0;
        cyc();
    endtask

    task automatic test_flush();
        ce = 1'b1; pc = 32'h10;
        cyc();
        n_tests++; if (bus.ibus_req_o !== 1'b1) begin n_fail++; $display("FAIL fl_req1: got %h expected 1", bus.ibus_req_o); end
        cyc();
        flush = 1'b1;
        #1;
        n_tests++; if (stallreq !== 1'b1) begin n_fail++; $display("FAIL fl_stallreq: got %h expected 1", stallreq); end
        cyc();
        flush = 1'b0; pc = 32'h20;
        n_tests++; if ({bus.ibus_req_o, if_valid} !== 2'b10) begin n_fail++; $display("FAIL fl_drain3: got %b expected 10", {bus.ibus_req_o, if_valid}); end
        n_tests++; if (bus.ibus_addr_o !== 32'h10) begin n_fail++; $display("FAIL fl_addr_stable: got %h expected 10", bus.ibus_addr_o); end
        cyc();
        flush = 1'b1;
        #1;
        n_tests++; if ({bus.ibus_req_o, stallreq} !== 2'b11) begin n_fail++; $display("FAIL fl_drain4: got %b expected 11", {bus.ibus_req_o, stallreq}); end
        cyc();
        flush = 1'b0;
        n_tests++; if (bus.ibus_req_o !== 1'b1) begin n_fail++; $display("FAIL fl_drain5: got %h expected 1", bus.ibus_req_o); end
        bus.ibus_ack_i = 1'b1; bus.ibus_data_i = 32'hDEAD_BEEF;
        cyc();
        bus.ibus_ack_i = 1'b0; bus.ibus_data_i = 32'h0;
        n_tests++; if ({bus.ibus_req_o, if_valid} !== 2'b00) begin n_fail++; $display("FAIL fl_drained: got %b expected 00", {bus.ibus_req_o, if_valid}); end
        n_tests++; if (if_inst !== 32'h7777_8888) begin n_fail++; $display("FAIL fl_discard: got %h expected 77778888", if_inst); end
        cyc();
        n_tests++; if (bus.ibus_addr_o !== 32'h20) begin n_fail++; $display("FAIL fl_newpc: got %h expected 20", bus.ibus_addr_o); end
        bus.ibus_ack_i = 1'b1; bus.ibus_data_i = 32'hCAFE_F00D;
        cyc();
        bus.ibus_ack_i = 1'b0; bus.ibus_data_i = 32'h0;
        n_tests++; if ({if_valid, if_pc, if_inst} !== {1'b1, 32'h20, 32'hCAFE_F00D}) begin n_fail++; $display("FAIL fl_deliver: got %h expected 100000020cafef00d", {if_valid, if_pc, if_inst}); end
        ce = 1'b0;
        cyc();
    endtask

    task automatic test_misaligned();
        ce = 1'b1; pc = 32'h102;
        #1;
        n_tests++; if ({bus.ibus_req_o, stallreq} !== 2'b01) begin n_fail++; $display("FAIL m_idle: got %b expected 01", {bus.ibus_req_o, stallreq}); end
        cyc();
        n_tests++; if (bus.ibus_req_o !== 1'b0) begin n_fail++; $display("FAIL m_noreq: got %h expected 0", bus.ibus_req_o); end
        n_tests++; if ({if_valid, if_err} !== 2'b11) begin n_fail++; $display("FAIL m_flags: got %b expected 11", {if_valid, if_err}); end
        n_tests++; if (if_inst !== 32'h0) begin n_fail++; $display("FAIL m_inst: got %h expected 0", if_inst); end
        n_tests++; if (if_pc !== 32'h102) begin n_fail++; $display("FAIL m_pc: got %h expected 102", if_pc); end
        ce = 1'b0;
        cyc();
        n_tests++; if ({bus.ibus_req_o, if_valid} !== 2'b00) begin n_fail++; $display("FAIL m_after: got %b expected 00", {bus.ibus_req_o, if_valid}); end
    endtask

    task automatic test_timeout();
        ce4 = 1'b1; pc4 = 32'h40;
        cyc();
        for (int i = 1; i <= 4; i++) begin
            n_tests++; if (bus4.ibus_req_o !== 1'b1) begin n_fail++; $display("FAIL to_req[%0d]: got %h expected 1", i, bus4.ibus_req_o); end
            cyc();
        end
        n_tests++; if (bus4.ibus_req_o !== 1'b0) begin n_fail++; $display("FAIL to_abort: got %h expected 0", bus4.ibus_req_o); end
        n_tests++; if ({if_valid4, if_err4, stallreq4} !== 3'b110) begin n_fail++; $display("FAIL to_flags: got %b expected 110", {if_valid4, if_err4, stallreq4}); end
        n_tests++; if (if_inst4 !== 32'h0) begin n_fail++; $display("FAIL to_inst: got %h expected 0", if_inst4); end
        ce4 = 1'b0;
        cyc();
        bus4.ibus_ack_i = 1'b1; bus4.ibus_data_i = 32'h0000_0055;
        cyc();
        bus4.ibus_ack_i = 1'b0; bus4.ibus_data_i = 32'h0;
        n_tests++; if ({bus4.ibus_req_o, if_valid4, stallreq4} !== 3'b000) begin n_fail++; $display("FAIL to_late_ack: got %b expected 000", {bus4.ibus_req_o, if_valid4, stallreq4}); end
        n_tests++; if (if_inst4 !== 32'h0) begin n_fail++; $display("FAIL to_late_inst: got %h expected 0", if_inst4); end
    endtask

    task automatic test_ack_at_timeout();
        ce4 = 1'b1; pc4 = 32'h44;
        cyc();
        cyc();
        cyc();
        cyc();
        n_tests++; if (bus4.ibus_req_o !== 1'b1) begin n_fail++; $display("FAIL at_req4: got %h expected 1", bus4.ibus_req_o); end
        bus4.ibus_ack_i = 1'b1; bus4.ibus_data_i = 32'hA5A5_5A5A;
        cyc();
        bus4.ibus_ack_i = 1'b0; bus4.ibus_data_i = 32'h0;
        n_tests++; if ({if_valid4, if_err4} !== 2'b10) begin n_fail++; $display("FAIL at_flags: got %b expected 10", {if_valid4, if_err4}); end
        n_tests++; if ({if_pc4, if_inst4} !== {32'h44, 32'hA5A5_5A5A}) begin n_fail++; $display("FAIL at_data: got %h expected 00000044a5a55a5a", {if_pc4, if_inst4}); end
        ce4 = 1'b0;
        cyc();
    endtask

    task automatic test_async_reset();
        ce = 1'b1; pc = 32'h80;
        cyc();
        n_tests++; if ({bus.ibus_req_o, bus.ibus_addr_o} !== {1'b1, 32'h80}) begin n_fail++; $display("FAIL ar_req: got %h expected 100000080", {bus.ibus_req_o, bus.ibus_addr_o}); end
        #3;
        rst_n = 1'b0; ce = 1'b0;
        #1;
        n_tests++; if ({bus.ibus_req_o, bus.ibus_addr_o} !== 33'h0) begin n_fail++; $display("FAIL ar_bus: got %h expected 0", {bus.ibus_req_o, bus.ibus_addr_o}); end
        n_tests++; if ({if_pc, if_inst} !== 64'h0) begin n_fail++; $display("FAIL ar_data: got %h expected 0", {if_pc, if_inst}); end
        n_tests++; if ({if_valid, if_err, stallreq} !== 3'b000) begin n_fail++; $display("FAIL ar_flags: got %b expected 000", {if_valid, if_err, stallreq}); end
        #2;
        rst_n = 1'b1;
        cyc();
        n_tests++; if ({bus.ibus_req_o, stallreq, if_valid} !== 3'b000) begin n_fail++; $display("FAIL ar_idle: got %b expected 000", {bus.ibus_req_o, stallreq, if_valid}); end
        bus.ibus_ack_i = 1'b1; bus.ibus_data_i = 32'h0000_0099;
        cyc();
        bus.ibus_ack_i = 1'b0; bus.ibus_data_i = 32'h0;
        n_tests++; if ({bus.ibus_req_o, if_valid, stallreq} !== 3'b000) begin n_fail++; $display("FAIL ar_stale: got %b expected 000", {bus.ibus_req_o, if_valid, stallreq}); end
        n_tests++; if (if_inst !== 32'h0) begin n_fail++; $display("FAIL ar_stale_inst: got %h expected 0", if_inst); end
    endtask

    initial begin
        rst_n = 1'b0;
        pc = '0; ce = 1'b0; stall = '0; flush = 1'b0;
        pc4 = '0; ce4 = 1'b0; stall4 = '0; flush4 = 1'b0;
        bus.ibus_ack_i = 1'b0;  bus.ibus_data_i = '0;
        bus4.ibus_ack_i = 1'b0; bus4.ibus_data_i = '0;

        test_reset();
        test_fetch();
        test_stall();
        test_flush();
        test_misaligned();
        test_timeout();
        test_ack_at_timeout();
        test_async_reset();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
